sma_pulse_gen: RTL
==================

SMA_PULSE_GEN -- requirements
Module: sma_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of period/high/count registers and counters.
REQ-002 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port gate  input  1  run enable, driven by the SMA output PIO out_port, synchronous to clk.
REQ-005 SHALL have port address  input  2  Avalon-MM slave register select.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  read data, zero-wait combinational on address.
REQ-010 SHALL have port sma_o  output  1  registered pulse-train output to SMA connector.
REQ-011 SHALL have port busy  output  1  high while state is not IDLE/DONE.

Function
REQ-012 SHALL decode registers: 0 PERIOD, 1 HIGH, 2 COUNT, 3 STATUS; write when chipselect & ~write_n, unused writedata bits ignored.
REQ-013 SHALL read back PERIOD/HIGH/COUNT zero-extended; STATUS = {pulses_done[CNT_W-1:0] at bits 31:16 truncated/zero-padded, bit1 done, bit0 busy}.
REQ-014 SHALL write STATUS bit1=1 to clear done; other STATUS write bits ignored.
REQ-015 SHALL implement FSM states IDLE, HIGH, LOW, DONE.
REQ-016 SHALL start on gate rising edge (gate=1, gate_q=0) from IDLE or DONE: latch shadow copies of PERIOD/HIGH/COUNT, clear pulses_done and done, enter HIGH.
REQ-017 SHALL drive sma_o=1 from the cycle after the starting edge is sampled (latency 1 clk).
REQ-018 SHALL hold HIGH for shadow HIGH cycles, then LOW for (PERIOD-HIGH) cycles; one period = PERIOD cycles exactly.
REQ-019 SHALL clamp effective PERIOD to minimum 2 when PERIOD<2.
REQ-020 SHALL, when HIGH=0, skip the HIGH state (sma_o stays 0 whole period) but still count the pulse.
REQ-021 SHALL, when HIGH>=PERIOD, keep sma_o=1 the whole period (LOW phase of length 0 skipped).
REQ-022 SHALL increment pulses_done at each period end; if COUNT!=0 and pulses_done reaches COUNT, enter DONE, set done, sma_o=0.
REQ-023 SHALL run continuously when COUNT=0 until gate falls.
REQ-024 SHALL apply register writes made during a run only at the next period start (shadow reload at each period boundary).
REQ-025 SHALL abort on gate=0 in HIGH/LOW: go IDLE, sma_o=0 next cycle, done not set, pulses_done holds value.
REQ-026 SHALL, on simultaneous period end and gate fall, take the abort (pulses_done still incremented).
REQ-027 SHALL remain in DONE while gate stays high; a new rising edge restarts per REQ-016.
REQ-028 SHALL wrap pulses_done modulo 2^CNT_W in continuous mode.

Reset
REQ-029 SHALL on reset_n=0 set state IDLE, sma_o=0, busy=0, done=0, gate_q=0, pulses_done=0, PERIOD=0, HIGH=0, COUNT=0, shadows=0.
REQ-030 SHALL treat reset mid-run as immediate abort with sma_o low asynchronously.
REQ-031 SHALL not start on the first clock after reset release unless gate is observed rising (gate_q resets to 0, so gate held high through reset DOES start).

Structure
REQ-032 SHALL place state enum, register address constants (ADDR_PERIOD..ADDR_STATUS) and STATUS bit positions in shared package sma_pkg.
REQ-033 SHALL be a single module plus one sub-module sma_phase_cnt (loadable down-counter with zero flag) instantiated once for the phase timer.

Verification
REQ-034 PERIOD=10, HIGH=3, COUNT=4, gate 0->1 -> four pulses 3 high/7 low, sma_o rises 1 clk after edge, DONE, STATUS=0x0004_0002.
REQ-035 PERIOD=4, HIGH=0, COUNT=2 -> sma_o never high, done set after 8 clks, pulses_done=2.
REQ-036 PERIOD=5, HIGH=7, COUNT=0 -> sma_o constantly 1; gate falls -> sma_o 0 next clk, busy 0, done 0.
REQ-037 Run PERIOD=8,HIGH=4; write HIGH=2 mid-HIGH phase -> current period 4/4, next period 2/6.
REQ-038 PERIOD=1, HIGH=1, COUNT=3 -> effective period 2, pattern 1,1,1,1,1,1 then 0, done after 6 clks.
REQ-039 reset_n pulse low mid-LOW phase -> sma_o 0 immediately, all registers read 0 after release.

Source files
------------

// File: rtl/sma_pkg.sv
// Shared definitions for the SMA pulse-train generator: FSM states,
// Avalon register map and STATUS bit layout.
package sma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } sma_state_e;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_HIGH   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_PD_LSB   = 16;

endpackage

// File: rtl/sma_phase_cnt.sv
// Loadable down-counter used as the phase timer; zero marks the last
// cycle of the phase that was loaded with (length - 1).
module sma_phase_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sma_pulse_gen.sv
// Gate-triggered pulse-train generator with an Avalon-MM register slave.
// Handshake: a write is accepted in any cycle with chipselect=1 and write_n=0; reads are zero-wait.
module sma_pulse_gen
  import sma_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        gate,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sma_o,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  sma_state_e       fsm;
  logic [CNT_W-1:0] period_r, high_r, count_r;
  logic [CNT_W-1:0] sh_low, sh_count, pulses_done, pd_next;
  logic [CNT_W-1:0] p_eff, h_eff, l_len, cnt_val;
  logic [15:0]      pd16;
  logic             gate_q, done, wr, unused_wd;
  logic             phase_zero, start_evt, to_low, period_end, finish;
  logic             new_period, cnt_load;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_r <= '0;
      high_r   <= '0;
      count_r  <= '0;
    end else if (wr) begin
      case (address)
        ADDR_PERIOD: period_r <= writedata[CNT_W-1:0];
        ADDR_HIGH:   high_r   <= writedata[CNT_W-1:0];
        ADDR_COUNT:  count_r  <= writedata[CNT_W-1:0];
        default:     ;
      endcase
    end
  end

  // Phase lengths of the next period, taken from the live registers.
  // HIGH is compared with the raw PERIOD, so HIGH>=PERIOD fills the clamped period.
  assign p_eff = (period_r < TWO) ? TWO : period_r;
  assign h_eff = (high_r == '0) ? '0 : ((high_r >= period_r) ? p_eff : high_r);
  assign l_len = p_eff - h_eff;

  assign busy       = (fsm == ST_HIGH) || (fsm == ST_LOW);
  assign fsm_state  = fsm;
  assign pd_next    = pulses_done + ONE;
  assign start_evt  = !busy && gate && !gate_q;
  assign to_low     = (fsm == ST_HIGH) && phase_zero && (sh_low != '0) && gate;
  assign period_end = phase_zero &&
                      (((fsm == ST_HIGH) && (sh_low == '0)) || (fsm == ST_LOW));
  assign finish     = (sh_count != '0) && (pd_next == sh_count);
  assign new_period = start_evt || (period_end && gate && !finish);
  assign cnt_load   = new_period || to_low;
  assign cnt_val    = to_low ? (sh_low - ONE)
                    : ((h_eff != '0) ? (h_eff - ONE) : (l_len - ONE));

  sma_phase_cnt #(.W(CNT_W)) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (phase_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm         <= ST_IDLE;
      sma_o       <= 1'b0;
      done        <= 1'b0;
      gate_q      <= 1'b0;
      pulses_done <= '0;
      sh_low      <= '0;
      sh_count    <= '0;
    end else begin
      gate_q <= gate;
      if (wr && (address == ADDR_STATUS) && writedata[STATUS_DONE_BIT])
        done <= 1'b0;
      if (period_end && busy)
        pulses_done <= pd_next;
      if (new_period) begin
        sh_low   <= l_len;
        sh_count <= count_r;
        fsm      <= (h_eff != '0) ? ST_HIGH : ST_LOW;
        sma_o    <= (h_eff != '0);
        if (start_evt) begin
          pulses_done <= '0;
          done        <= 1'b0;
        end
      end else if (busy && !gate) begin
        fsm   <= ST_IDLE;
        sma_o <= 1'b0;
      end else if (to_low) begin
        fsm   <= ST_LOW;
        sma_o <= 1'b0;
      end else if (period_end && finish) begin
        fsm   <= ST_DONE;
        done  <= 1'b1;
        sma_o <= 1'b0;
      end
    end
  end

  assign pd16 = 16'(pulses_done);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_PERIOD: readdata = 32'(period_r);
      ADDR_HIGH:   readdata = 32'(high_r);
      ADDR_COUNT:  readdata = 32'(count_r);
      ADDR_STATUS: begin
        readdata[STATUS_PD_LSB +: 16]  = pd16;
        readdata[STATUS_DONE_BIT]      = done;
        readdata[STATUS_BUSY_BIT]      = busy;
      end
      default: readdata = '0;
    endcase
  end

endmodule
